mem_stage_wbuf: RTL and testbench
=================================

// Module: mem_stage_wbuf
// PURPOSE
//  Parametrised MEM pipeline stage. Registers mem_ir and its result into the WB stage.
//  Buffers stores in a WBUF_DEPTH-entry FIFO write buffer that drains to data memory over a req/gnt handshake.
//  Services cache-miss loads with a request/response FSM and stalls the pipeline upstream while a miss or a full buffer is pending.
// PARAMETERS
//  DATA_W    16  data word width (reg_C1, smdr1, cache/memory data)
//  ADDR_W    16  data address width (taken from reg_C[ADDR_W-1:0])
//  IR_W      16  instruction width; opcode = ir[IR_W-1:IR_W-5]
//  WBUF_DEPTH 4  write-buffer entries, power of 2, >=2
// PORTS
//  clock      in   1          clock
//  reset      in   1          async active-low reset
//  state      in   1          stage advances only when state==`exec
//  mem_ir     in   IR_W       instruction in MEM
//  reg_C      in   DATA_W     ALU result / effective address
//  smdr1      in   DATA_W     store data
//  hit        in   1          cache hit for reg_C this cycle
//  cache_out  in   DATA_W     cache read data (valid when hit)
//  d_gnt      in   1          memory accepts d_req this cycle
//  d_rvalid   in   1          read data valid on d_rdata
//  d_rdata    in   DATA_W     memory read data
//  wb_ir      out  IR_W       instruction to WB
//  reg_C1     out  DATA_W     result to WB
//  d_req      out  1          memory request valid
//  d_we       out  1          1=write (buffer drain), 0=miss read
//  d_addr     out  ADDR_W     memory address
//  d_wdata    out  DATA_W     memory write data
//  stall      out  1          hold upstream stages
//  wbuf_cnt   out  log2(D)+1  write-buffer occupancy
// BEHAVIOUR
//  Reset: wb_ir=0, reg_C1=0, FSM=IDLE, buffer empty, d_req=0, d_we=0, stall=0, wbuf_cnt=0.
//  Updates occur only when state==`exec; otherwise all registers hold.
//  Non-mem op: 1-cycle latency, wb_ir<=mem_ir, reg_C1<=reg_C.
//  LOAD, hit, no forward: wb_ir<=mem_ir, reg_C1<=cache_out; 1 cycle.
//  LOAD miss: FSM IDLE->MREQ. In MREQ: d_req=1, d_we=0, d_addr=reg_C; on d_gnt -> MWAIT.
//   In MWAIT: on d_rvalid, reg_C1<=d_rdata, wb_ir<=mem_ir, -> IDLE.
//  STORE: enqueue {reg_C,smdr1}; wb_ir<=mem_ir, reg_C1<=reg_C. If count==WBUF_DEPTH, stall and do not enqueue.
//   No same-cycle pop/push bypass when full.
//  stall=1 combinationally while FSM!=IDLE, a miss is being launched, or a store meets a full buffer.
//   While stall=1, wb_ir<=0 (bubble) and reg_C1 holds, except on the completing cycle.
//  Drain: when FSM==IDLE and no miss is being launched and buffer not empty: d_req=1, d_we=1, head data is output; pop on d_gnt.
//  Priority: miss read > drain. A drain grant and a store enqueue may occur in the same cycle (count unchanged).
//  RAW: a LOAD whose address matches any buffered entry must not read stale memory (see CONFIGURATION).
//  Pointers wrap modulo WBUF_DEPTH; count saturates at 0 and at WBUF_DEPTH by construction.
//  Reset mid-miss: FSM returns to IDLE, buffer is flushed, and a late d_rvalid is ignored.
// CONFIGURATION
//  MEM_STORE_FWD_EN defined: a LOAD matching a buffer entry takes the youngest matching entry's data in 1 cycle.
//   No stall and no memory access; this overrides hit.
//  Undefined: a matching LOAD stalls until the buffer fully drains, then proceeds as hit or miss.
// STRUCTURE
//  Shared package mem_pkg: opcode constants LOAD/STORE/NOP, `exec, FSM state enum {IDLE,MREQ,MWAIT}, opcode slice helper.
//  Sub-module mem_wbuf_fifo: FIFO with push/pop/full/empty/count and a per-entry address-match vector.
//  The top level holds the FSM, the stall logic and the WB registers.
// TESTING
//  1 ADD, reg_C=16'h1234, state=exec -> next cycle wb_ir=ADD, reg_C1=16'h1234, stall=0.
//  2 LOAD hit, cache_out=16'hBEEF -> reg_C1=16'hBEEF after 1 cycle, d_req stays 0.
//  3 LOAD miss @16'h0040, d_gnt after 2 cycles, d_rvalid 3 cycles later with 16'hCAFE ->
//    stall high throughout, wb_ir=0 bubbles, then reg_C1=16'hCAFE, FSM=IDLE.
//  4 Five STOREs back-to-back with d_gnt=0, depth 4 -> wbuf_cnt=4, stall on 5th.
//    Raise d_gnt -> head address is written first, then the 5th store enqueues.
//  5 STORE 16'h0010<=16'h5555 then LOAD 16'h0010 with d_gnt=0 ->
//    with MEM_STORE_FWD_EN: reg_C1=16'h5555 in 1 cycle; without it: stall until wbuf_cnt=0.
//  6 Assert reset during MWAIT with 2 buffered stores -> all outputs 0, wbuf_cnt=0, later d_rvalid ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: opcodes, exec state code, miss FSM states, opcode slice.
`ifndef EXEC
`define EXEC 1'b1
`endif

package mem_pkg;

    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] LOAD  = 5'b10000;
    localparam logic [4:0] STORE = 5'b10001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2
    } fsm_t;

    // The opcode is the top five bits of an ir_w-bit instruction, passed zero-extended.
    function automatic logic [4:0] opcode_of(input logic [31:0] ir, input int ir_w);
        return ir[ir_w-1 -: 5];
    endfunction

endpackage

// File: rtl/mem_stage_wbuf_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_stage_wbuf_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    modport master (
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata
    );
endinterface

// File: rtl/mem_wbuf_fifo.sv
// Store write buffer: circular FIFO of {addr,data} with per-slot address match and youngest-match data.
// Push is ignored when full and pop when empty, so count stays within 0..DEPTH.
module mem_wbuf_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [DEPTH-1:0]  match,
    output logic [DATA_W-1:0] fwd_data
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Walk slots oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        logic [PW-1:0] age;
        match    = '0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age      = PW'(i) - rd_ptr_q;
            match[i] = (CW'(age) < cnt_q) && (addr_q[i] == lookup_addr);
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < cnt_q) && (addr_q[idx] == lookup_addr)) begin
                fwd_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_stage_wbuf.sv
// MEM pipeline stage with store write buffer and cache-miss load FSM; optional store-to-load forwarding via MEM_STORE_FWD_EN.
// Stall is combinational: asserted while a miss is launched/outstanding, a store meets a full buffer, or (no forwarding) a load hits the buffer.
module mem_stage_wbuf import mem_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int IR_W       = 16,
    parameter int WBUF_DEPTH = 4,
    localparam int CW        = $clog2(WBUF_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              state,
    input  logic [IR_W-1:0]   mem_ir,
    input  logic [DATA_W-1:0] reg_C,
    input  logic [DATA_W-1:0] smdr1,
    input  logic              hit,
    input  logic [DATA_W-1:0] cache_out,
    mem_stage_wbuf_if.master  dbus,
    output logic [IR_W-1:0]   wb_ir,
    output logic [DATA_W-1:0] reg_C1,
    output logic              stall,
    output logic [CW-1:0]     wbuf_cnt
);
    fsm_t              fsm_q, fsm_d;
    logic [IR_W-1:0]   wb_ir_q, wb_ir_d;
    logic [DATA_W-1:0] reg_c1_q, reg_c1_d;

    logic              exec_en, is_load, is_store;
    logic [4:0]        op;
    logic [ADDR_W-1:0] addr;
    logic              full, empty, any_match;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data, fwd_data;
    logic [WBUF_DEPTH-1:0] match;
    logic              miss_launch, raw_block, fwd_take, store_full, push, pop;

    assign exec_en   = (state == `EXEC);
    assign op        = opcode_of(32'(mem_ir), IR_W);
    assign is_load   = (op == LOAD);
    assign is_store  = (op == STORE);
    assign addr      = reg_C[ADDR_W-1:0];
    assign any_match = |match;

    assign push = exec_en && is_store && (fsm_q == IDLE) && !full;
    assign pop  = dbus.d_req && dbus.d_we && dbus.d_gnt;

    mem_wbuf_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_addr   (addr),
        .push_data   (smdr1),
        .lookup_addr (addr),
        .full        (full),
        .empty       (empty),
        .count       (wbuf_cnt),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .match       (match),
        .fwd_data    (fwd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q    <= IDLE;
            wb_ir_q  <= '0;
            reg_c1_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            wb_ir_q  <= wb_ir_d;
            reg_c1_q <= reg_c1_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        if (exec_en) begin
            case (fsm_q)
                IDLE:    if (miss_launch)   fsm_d = MREQ;
                MREQ:    if (dbus.d_gnt)    fsm_d = MWAIT;
                MWAIT:   if (dbus.d_rvalid) fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    // A load that matches the buffer never launches a miss: it either forwards or waits for the drain.
    always_comb begin
        miss_launch  = 1'b0;
        raw_block    = 1'b0;
        fwd_take     = 1'b0;
        dbus.d_req   = 1'b0;
        dbus.d_we    = 1'b0;
        dbus.d_addr  = '0;
        dbus.d_wdata = '0;
        if (fsm_q == IDLE && is_load) begin
`ifdef MEM_STORE_FWD_EN
            fwd_take    = any_match;
`else
            raw_block   = any_match;
`endif
            miss_launch = !any_match && !hit;
        end
        store_full = is_store && full && (fsm_q == IDLE);
        stall      = (fsm_q != IDLE) || miss_launch || store_full || raw_block;
        if (exec_en) begin
            if (fsm_q == MREQ) begin
                dbus.d_req  = 1'b1;
                dbus.d_addr = addr;
            end else if (fsm_q == IDLE && !miss_launch && !empty) begin
                dbus.d_req   = 1'b1;
                dbus.d_we    = 1'b1;
                dbus.d_addr  = head_addr;
                dbus.d_wdata = head_data;
            end
        end
    end

    always_comb begin
        wb_ir_d  = wb_ir_q;
        reg_c1_d = reg_c1_q;
        if (exec_en) begin
            if (fsm_q == MWAIT && dbus.d_rvalid) begin
                wb_ir_d  = mem_ir;
                reg_c1_d = dbus.d_rdata;
            end else if (stall) begin
                wb_ir_d  = '0;
            end else begin
                wb_ir_d = mem_ir;
                if (fwd_take)     reg_c1_d = fwd_data;
                else if (is_load) reg_c1_d = cache_out;
                else              reg_c1_d = reg_C;
            end
        end
    end

    assign wb_ir  = wb_ir_q;
    assign reg_C1 = reg_c1_q;
endmodule

// File: tb/tb_mem_stage_wbuf.sv
// Directed bench for mem_stage_wbuf: ALU pass-through, hit, miss, full buffer, RAW, reset mid-miss.
module tb_mem_stage_wbuf;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        state = 1'b0;
    logic [15:0] mem_ir = '0, reg_C = '0, smdr1 = '0, cache_out = '0;
    logic        hit = 1'b0;
    logic [15:0] wb_ir, reg_C1;
    logic        stall;
    logic [2:0]  wbuf_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [15:0] IR_ADD = 16'h0801;
    localparam logic [15:0] IR_LDH = 16'h8002;
    localparam logic [15:0] IR_LDM = 16'h8003;
    localparam logic [15:0] IR_ST  = 16'h8804;
    localparam logic [15:0] IR_ST2 = 16'h8806;
    localparam logic [15:0] IR_LDR = 16'h8007;
    localparam logic [15:0] IR_ST3 = 16'h8805;
    localparam logic [15:0] IR_LD6 = 16'h8008;

    mem_stage_wbuf_if #(.DATA_W(16), .ADDR_W(16)) dbus ();

    mem_stage_wbuf #(.DATA_W(16), .ADDR_W(16), .IR_W(16), .WBUF_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .state     (state),
        .mem_ir    (mem_ir),
        .reg_C     (reg_C),
        .smdr1     (smdr1),
        .hit       (hit),
        .cache_out (cache_out),
        .dbus      (dbus),
        .wb_ir     (wb_ir),
        .reg_C1    (reg_C1),
        .stall     (stall),
        .wbuf_cnt  (wbuf_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        dbus.d_gnt    = 1'b0;
        dbus.d_rvalid = 1'b0;
        dbus.d_rdata  = '0;

        // reset state
        #3;
        check("rst_wb_ir", wb_ir, 16'h0);
        check("rst_reg_c1", reg_C1, 16'h0);
        check("rst_d_req", 16'(dbus.d_req), 16'h0);
        check("rst_d_we", 16'(dbus.d_we), 16'h0);
        check("rst_stall", 16'(stall), 16'h0);
        check("rst_cnt", 16'(wbuf_cnt), 16'h0);
        tick();
        reset = 1'b1;
        state = 1'b1;

        // 1: ALU op passes through in one cycle
        mem_ir = IR_ADD; reg_C = 16'h1234;
        tick();
        check("add_wb_ir", wb_ir, IR_ADD);
        check("add_reg_c1", reg_C1, 16'h1234);
        check("add_stall", 16'(stall), 16'h0);

        // 2: load hit
        mem_ir = IR_LDH; reg_C = 16'h0020; hit = 1'b1; cache_out = 16'hBEEF;
        #1;
        check("hit_d_req_pre", 16'(dbus.d_req), 16'h0);
        tick();
        check("hit_reg_c1", reg_C1, 16'hBEEF);
        check("hit_wb_ir", wb_ir, IR_LDH);
        check("hit_d_req", 16'(dbus.d_req), 16'h0);

        // 3: load miss, grant after 2 cycles, data 3 cycles later
        mem_ir = IR_LDM; reg_C = 16'h0040; hit = 1'b0;
        #1;
        check("miss_launch_stall", 16'(stall), 16'h1);
        check("miss_launch_req", 16'(dbus.d_req), 16'h0);
        tick();
        check("mreq_req", 16'(dbus.d_req), 16'h1);
        check("mreq_we", 16'(dbus.d_we), 16'h0);
        check("mreq_addr", dbus.d_addr, 16'h0040);
        check("mreq_stall", 16'(stall), 16'h1);
        check("mreq_bubble", wb_ir, 16'h0);
        check("mreq_hold_c1", reg_C1, 16'hBEEF);
        tick();
        check("mreq2_req", 16'(dbus.d_req), 16'h1);
        dbus.d_gnt = 1'b1;
        tick();
        dbus.d_gnt = 1'b0;
        #1;
        check("mwait_req", 16'(dbus.d_req), 16'h0);
        check("mwait_stall", 16'(stall), 16'h1);
        tick();
        tick();
        check("mwait_bubble", wb_ir, 16'h0);
        check("mwait_stall2", 16'(stall), 16'h1);
        dbus.d_rvalid = 1'b1; dbus.d_rdata = 16'hCAFE;
        tick();
        check("miss_reg_c1", reg_C1, 16'hCAFE);
        check("miss_wb_ir", wb_ir, IR_LDM);
        dbus.d_rvalid = 1'b0; mem_ir = NOP; reg_C = 16'h0;
        #1;
        check("miss_done_stall", 16'(stall), 16'h0);
        check("miss_done_req", 16'(dbus.d_req), 16'h0);
        tick();

        // 4: five stores into a 4-deep buffer with no grant
        mem_ir = IR_ST;
        for (int i = 0; i < 4; i++) begin
            reg_C = 16'h0100 + 16'(i); smdr1 = 16'hA000 + 16'(i);
            tick();
        end
        check("full_cnt", 16'(wbuf_cnt), 16'h4);
        reg_C = 16'h0104; smdr1 = 16'hA004;
        #1;
        check("full_stall", 16'(stall), 16'h1);
        check("full_head_addr", dbus.d_addr, 16'h0100);
        tick();
        check("full_cnt_hold", 16'(wbuf_cnt), 16'h4);
        check("full_bubble", wb_ir, 16'h0);
        dbus.d_gnt = 1'b1;
        #1;
        check("drain_req", 16'(dbus.d_req), 16'h1);
        check("drain_we", 16'(dbus.d_we), 16'h1);
        check("drain_addr0", dbus.d_addr, 16'h0100);
        check("drain_data0", dbus.d_wdata, 16'hA000);
        tick();
        dbus.d_gnt = 1'b0;
        #1;
        check("after_pop_cnt", 16'(wbuf_cnt), 16'h3);
        check("after_pop_stall", 16'(stall), 16'h0);
        tick();
        check("st5_cnt", 16'(wbuf_cnt), 16'h4);
        check("st5_wb_ir", wb_ir, IR_ST);
        check("st5_reg_c1", reg_C1, 16'h0104);
        mem_ir = NOP; reg_C = 16'h0; dbus.d_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain_addr", dbus.d_addr, 16'h0101 + 16'(k));
            check("drain_data", dbus.d_wdata, 16'hA001 + 16'(k));
            tick();
        end
        dbus.d_gnt = 1'b0;
        #1;
        check("drained_cnt", 16'(wbuf_cnt), 16'h0);
        check("drained_req", 16'(dbus.d_req), 16'h0);

        // 5: store then load of the same address with the buffer stuck
        mem_ir = IR_ST2; reg_C = 16'h0010; smdr1 = 16'h5555;
        tick();
        mem_ir = IR_LDR; hit = 1'b1; cache_out = 16'h1111;
        #1;
`ifdef MEM_STORE_FWD_EN
        check("fwd_stall", 16'(stall), 16'h0);
        tick();
        check("fwd_reg_c1", reg_C1, 16'h5555);
        check("fwd_wb_ir", wb_ir, IR_LDR);
        check("fwd_cnt", 16'(wbuf_cnt), 16'h1);
        mem_ir = NOP; dbus.d_gnt = 1'b1;
        tick();
        dbus.d_gnt = 1'b0;
`else
        check("raw_stall", 16'(stall), 16'h1);
        tick();
        check("raw_bubble", wb_ir, 16'h0);
        check("raw_cnt", 16'(wbuf_cnt), 16'h1);
        dbus.d_gnt = 1'b1;
        tick();
        dbus.d_gnt = 1'b0;
        check("raw_drained", 16'(wbuf_cnt), 16'h0);
        #1;
        check("raw_release", 16'(stall), 16'h0);
        tick();
        check("raw_reg_c1", reg_C1, 16'h1111);
        check("raw_wb_ir", wb_ir, IR_LDR);
        mem_ir = NOP;
`endif
        hit = 1'b0;

        // 6: reset asserted while waiting on a miss with two stores buffered
        mem_ir = IR_ST3; reg_C = 16'h0200; smdr1 = 16'h0001;
        tick();
        reg_C = 16'h0201;
        tick();
        check("r6_cnt", 16'(wbuf_cnt), 16'h2);
        mem_ir = IR_LD6; reg_C = 16'h0300;
        tick();
        dbus.d_gnt = 1'b1;
        tick();
        dbus.d_gnt = 1'b0;
        #1;
        check("r6_mwait_stall", 16'(stall), 16'h1);
        mem_ir = NOP; reg_C = 16'h0077;
        #1;
        reset = 1'b0;
        #1;
        check("r6_wb_ir", wb_ir, 16'h0);
        check("r6_reg_c1", reg_C1, 16'h0);
        check("r6_d_req", 16'(dbus.d_req), 16'h0);
        check("r6_d_we", 16'(dbus.d_we), 16'h0);
        check("r6_stall", 16'(stall), 16'h0);
        check("r6_cnt0", 16'(wbuf_cnt), 16'h0);
        @(negedge clock);
        reset = 1'b1;
        dbus.d_rvalid = 1'b1; dbus.d_rdata = 16'hDEAD;
        tick();
        dbus.d_rvalid = 1'b0;
        check("late_rvalid_c1", reg_C1, 16'h0077);
        check("late_rvalid_ir", wb_ir, 16'h0);
        check("late_rvalid_stall", 16'(stall), 16'h0);
        check("late_rvalid_cnt", 16'(wbuf_cnt), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
